ring_wh_router: RTL and testbench

Parametrised wormhole ring router node: the next-generation per-node block of the ring interconnect, replacing the fixed 64-bit/9-flit node with configurable flit width, packet length, ID width and input buffer depth. It switches two inputs (upstream ring link, local core injection) to two outputs (downstream ring link, local ejection) at packet granularity. The ring links use credit-based flow control, so downstream buffers never overflow. One instance sits at each ring position; `NUMNODES` instances chain in a ring.

---
 rtl/ring_wh_router.sv | 219 +++++++++++++++++++++
 tb/tb_ring_wh_router.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_wh_router.sv
// Wormhole ring router node: an upstream ring input FIFO and an unbuffered core
// injection port are switched to the downstream ring link and local ejection, one packet at a time.
module ring_wh_router #(
  parameter int FLIT_W    = 64,
  parameter int PKT_FLITS = 9,
  parameter int ID_W      = 8,
  parameter int DEST_LSB  = 48,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [ID_W-1:0]   node_id,
  input  logic              ring_in_valid,
  input  logic [FLIT_W-1:0] ring_in_flit,
  output logic              ring_in_credit,
  output logic              ring_out_valid,
  output logic [FLIT_W-1:0] ring_out_flit,
  input  logic              ring_out_credit,
  input  logic              inj_valid,
  input  logic [FLIT_W-1:0] inj_flit,
  output logic              inj_ready,
  output logic              ej_valid,
  output logic [FLIT_W-1:0] ej_flit,
  input  logic              ej_ready,
  output logic              overflow_err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int FC_W  = $clog2(PKT_FLITS);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [FC_W-1:0]  LAST_FLIT = FC_W'(PKT_FLITS - 1);
  localparam logic OWN_RING = 1'b0;
  localparam logic OWN_INJ  = 1'b1;

  logic [FLIT_W-1:0] fifo_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, credits;
  logic [FC_W-1:0]   ring_cnt, inj_cnt;
  logic              ring_route, inj_route;
  logic              ro_lock, ro_owner, ro_rr;
  logic              ej_lock, ej_owner, ej_rr;

  logic [FLIT_W-1:0] fifo_head;
  logic              fifo_full, ring_avail, wr_en;
  logic              ring_head, inj_head, ring_to_ej, inj_to_ej;
  logic              rq_ring_ro, rq_ring_ej, rq_inj_ro, rq_inj_ej;
  logic [1:0]        ro_gnt, ej_gnt;
  logic              ro_xfer_ring, ro_xfer_inj, ej_xfer_ring, ej_xfer_inj;
  logic              ro_send, ring_pop, ro_tie, ej_tie;

  // Returns {grant_inj, grant_ring}; a locked output only serves its owner, rr=1 favours injection.
  function automatic logic [1:0] arbitrate(input logic lock, input logic owner, input logic rr,
                                           input logic req_ring, input logic req_inj,
                                           input logic head_ring, input logic head_inj);
    logic [1:0] gnt;
    if (lock) begin
      gnt = {req_inj && (owner == OWN_INJ), req_ring && (owner == OWN_RING)};
    end else if (req_ring && head_ring && req_inj && head_inj) begin
      gnt = rr ? 2'b10 : 2'b01;
    end else begin
      gnt = {req_inj && head_inj, req_ring && head_ring};
    end
    return gnt;
  endfunction

  // Route decode, arbitration and transfer qualification.
  always_comb begin
    fifo_head  = fifo_mem[rd_ptr];
    fifo_full  = (fifo_cnt == DEPTH_C);
    ring_avail = (fifo_cnt != '0);
    wr_en      = ring_in_valid && !fifo_full;
    ring_head  = (ring_cnt == '0);
    inj_head   = (inj_cnt == '0);
    if (ring_head) begin
      ring_to_ej = (fifo_head[DEST_LSB +: ID_W] == node_id);
    end else begin
      ring_to_ej = ring_route;
    end
    if (inj_head) begin
      inj_to_ej = (inj_flit[DEST_LSB +: ID_W] == node_id);
    end else begin
      inj_to_ej = inj_route;
    end
    rq_ring_ro = ring_avail && !ring_to_ej;
    rq_ring_ej = ring_avail && ring_to_ej;
    rq_inj_ro  = inj_valid && !inj_to_ej;
    rq_inj_ej  = inj_valid && inj_to_ej;
    ro_gnt = arbitrate(ro_lock, ro_owner, ro_rr, rq_ring_ro, rq_inj_ro, ring_head, inj_head);
    ej_gnt = arbitrate(ej_lock, ej_owner, ej_rr, rq_ring_ej, rq_inj_ej, ring_head, inj_head);
    ro_xfer_ring = ro_gnt[0] && (credits != '0);
    ro_xfer_inj  = ro_gnt[1] && (credits != '0);
    ej_xfer_ring = ej_gnt[0] && ej_ready;
    ej_xfer_inj  = ej_gnt[1] && ej_ready;
    ro_send   = ro_xfer_ring || ro_xfer_inj;
    ring_pop  = ro_xfer_ring || ej_xfer_ring;
    inj_ready = ro_xfer_inj || ej_xfer_inj;
    ej_valid  = |ej_gnt;
    if (ej_gnt[1]) begin
      ej_flit = inj_flit;
    end else begin
      ej_flit = fifo_head;
    end
    ro_tie = !ro_lock && ring_head && inj_head && rq_ring_ro && rq_inj_ro;
    ej_tie = !ej_lock && ring_head && inj_head && rq_ring_ej && rq_inj_ej;
  end

  // FIFO storage; contents are don't-care while the slot is empty, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= ring_in_flit;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (ring_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_en, ring_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Per-input flit position and the route latched from each head flit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ring_cnt   <= '0;
      inj_cnt    <= '0;
      ring_route <= 1'b0;
      inj_route  <= 1'b0;
    end else begin
      if (ring_pop) begin
        ring_cnt <= (ring_cnt == LAST_FLIT) ? '0 : ring_cnt + FC_W'(1);
        if (ring_head) begin
          ring_route <= ring_to_ej;
        end
      end
      if (inj_ready) begin
        inj_cnt <= (inj_cnt == LAST_FLIT) ? '0 : inj_cnt + FC_W'(1);
        if (inj_head) begin
          inj_route <= inj_to_ej;
        end
      end
    end
  end

  // Output locks: taken by a head transfer, dropped by the last flit, RR moves only on ties.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ro_lock  <= 1'b0;
      ro_owner <= OWN_RING;
      ro_rr    <= 1'b0;
      ej_lock  <= 1'b0;
      ej_owner <= OWN_RING;
      ej_rr    <= 1'b0;
    end else begin
      if (ro_xfer_ring) begin
        ro_lock  <= (ring_cnt != LAST_FLIT);
        ro_owner <= OWN_RING;
      end else if (ro_xfer_inj) begin
        ro_lock  <= (inj_cnt != LAST_FLIT);
        ro_owner <= OWN_INJ;
      end
      if (ej_xfer_ring) begin
        ej_lock  <= (ring_cnt != LAST_FLIT);
        ej_owner <= OWN_RING;
      end else if (ej_xfer_inj) begin
        ej_lock  <= (inj_cnt != LAST_FLIT);
        ej_owner <= OWN_INJ;
      end
      if (ro_tie && ro_send) begin
        ro_rr <= ro_xfer_ring;
      end
      if (ej_tie && (ej_xfer_ring || ej_xfer_inj)) begin
        ej_rr <= ej_xfer_ring;
      end
    end
  end

  // Downstream credits, registered outputs and the sticky protocol error.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      credits        <= DEPTH_C;
      ring_out_valid <= 1'b0;
      ring_out_flit  <= '0;
      ring_in_credit <= 1'b0;
      overflow_err   <= 1'b0;
    end else begin
      case ({ro_send, ring_out_credit})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= (credits == DEPTH_C) ? credits : credits + CNT_W'(1);
        default: credits <= credits;
      endcase
      ring_out_valid <= ro_send;
      if (ro_send) begin
        ring_out_flit <= ro_xfer_inj ? inj_flit : fifo_head;
      end
      ring_in_credit <= ring_pop;
      if ((ring_in_valid && fifo_full) ||
          (ring_out_credit && !ro_send && (credits == DEPTH_C))) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_wh_router.sv
// Directed bench for ring_wh_router (node 2): pass-through, eject with stall, contention,
// parallel transfer, credit exhaustion and reset mid-packet.
module tb_ring_wh_router;

  localparam int NF = 9;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [7:0]  node_id;
  logic        ring_in_valid, ring_in_credit, ring_out_valid, ring_out_credit;
  logic [63:0] ring_in_flit, ring_out_flit, inj_flit, ej_flit;
  logic        inj_valid, inj_ready, ej_valid, ej_ready, overflow_err;

  int n_checks = 0;
  int n_fails  = 0;
  int up_credit, ring_idx, inj_idx, outs, n_cred, ej_done, stall;
  logic [7:0] ring_tag, ring_dest;
  logic [63:0] exp_q[$];

  ring_wh_router dut (
    .clk(clk), .rst_l(rst_l), .node_id(node_id),
    .ring_in_valid(ring_in_valid), .ring_in_flit(ring_in_flit), .ring_in_credit(ring_in_credit),
    .ring_out_valid(ring_out_valid), .ring_out_flit(ring_out_flit), .ring_out_credit(ring_out_credit),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
    .ej_valid(ej_valid), .ej_flit(ej_flit), .ej_ready(ej_ready),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Head flit carries dest; body flits carry a different dest field so route latching matters.
  function automatic logic [63:0] mk(input logic [7:0] tag, input logic [7:0] dest, input int idx);
    logic [7:0] d;
    d = (idx == 0) ? dest : (dest ^ 8'h07);
    return {tag, d, 40'h0, 8'(idx)};
  endfunction

  // Credit-respecting upstream neighbour.
  task automatic drive_ring();
    if (ring_idx < NF && up_credit > 0) begin
      ring_in_valid = 1'b1;
      ring_in_flit  = mk(ring_tag, ring_dest, ring_idx);
      up_credit--;
      ring_idx++;
    end else begin
      ring_in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0; ring_in_valid = 1'b0; inj_valid = 1'b0; ring_out_credit = 1'b0; ej_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    up_credit = 4;
  endtask

  task automatic run_pass(input logic [7:0] tag);
    ring_tag = tag; ring_dest = 8'd5; ring_idx = 0; n_cred = 0;
    for (int w = 0; w < 14; w++) begin
      @(negedge clk);
      drive_ring();
      ring_out_credit = ring_out_valid;
      #1;
      check_eq("pt_ej_valid", ej_valid, 1'b0);
      check_eq("pt_out_valid", ring_out_valid, (w >= 2 && w <= 10));
      if (w >= 2 && w <= 10) check_eq("pt_out_flit", ring_out_flit, mk(tag, 8'd5, w - 2));
      if (ring_in_credit) begin n_cred++; up_credit++; end
    end
    check_eq("pt_credit_pulses", n_cred, 9);
  endtask

  task automatic run_contention(input bit ring_first);
    logic [7:0] itag;
    ring_tag = ring_first ? 8'h44 : 8'h46; itag = ring_tag + 8'h01;
    ring_dest = 8'd5; ring_idx = 0; inj_idx = 0; outs = 0;
    exp_q.delete();
    for (int k = 0; k < 2 * NF; k++) begin
      if ((k < NF) == ring_first) exp_q.push_back(mk(ring_tag, 8'd5, k % NF));
      else exp_q.push_back(mk(itag, 8'd5, k % NF));
    end
    for (int w = 0; w < 25; w++) begin
      @(negedge clk);
      drive_ring();
      inj_valid = (w >= 1 && inj_idx < NF);
      inj_flit  = mk(itag, 8'd5, inj_idx);
      ring_out_credit = ring_out_valid;
      #1;
      if (inj_valid) check_eq("cont_inj_ready", inj_ready, ring_first ? (w >= 10) : (w <= 9));
      if (inj_valid && inj_ready) inj_idx++;
      check_eq("cont_ej_valid", ej_valid, 1'b0);
      if (ring_out_valid) begin
        if (outs < 2 * NF) check_eq("cont_out_flit", ring_out_flit, exp_q[outs]);
        outs++;
      end
      if (ring_in_credit) up_credit++;
    end
    inj_valid = 1'b0;
    check_eq("cont_out_count", outs, 2 * NF);
  endtask

  initial begin
    rst_l = 1'b0; node_id = 8'd2; ring_in_valid = 1'b0; ring_in_flit = '0;
    ring_out_credit = 1'b0; inj_valid = 1'b0; inj_flit = '0; ej_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", ring_out_valid, 1'b0);
    check_eq("rst_out_flit", ring_out_flit, 64'h0);
    check_eq("rst_in_credit", ring_in_credit, 1'b0);
    check_eq("rst_overflow", overflow_err, 1'b0);
    check_eq("rst_ej_valid", ej_valid, 1'b0);
    rst_l = 1'b1;
    up_credit = 4;

    // Pass-through to ring_out.
    run_pass(8'h11);

    // Ejection with a three-cycle stall on flit 3.
    ring_tag = 8'h22; ring_dest = 8'd2; ring_idx = 0; ej_done = 0; stall = 0; n_cred = 0;
    for (int w = 0; w < 21; w++) begin
      @(negedge clk);
      drive_ring();
      ej_ready = !(ej_done == 3 && stall < 3);
      #1;
      if (w == 0) check_eq("ej_latency_w0", ej_valid, 1'b0);
      if (w == 1) check_eq("ej_latency_w1", ej_valid, 1'b1);
      if (ej_valid && !ej_ready) begin
        check_eq("ej_stall_flit", ej_flit, mk(8'h22, 8'd2, 3));
        if (stall > 0) check_eq("ej_stall_no_credit", ring_in_credit, 1'b0);
        stall++;
      end else if (ej_valid && ej_ready) begin
        if (ej_done < NF) check_eq("ej_flit", ej_flit, mk(8'h22, 8'd2, ej_done));
        ej_done++;
      end
      check_eq("ej_ring_out_idle", ring_out_valid, 1'b0);
      if (ring_in_credit) begin n_cred++; up_credit++; end
    end
    ej_ready = 1'b1;
    check_eq("ej_count", ej_done, NF);
    check_eq("ej_stall_cycles", stall, 3);
    check_eq("ej_credit_pulses", n_cred, NF);
    check_eq("ej_no_overflow", overflow_err, 1'b0);

    // Eject lock released: an injected packet to this node is accepted at once.
    inj_idx = 0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      inj_valid = (inj_idx < NF);
      inj_flit  = mk(8'h33, 8'd2, inj_idx);
      #1;
      if (inj_valid) begin
        check_eq("inj_ej_ready", inj_ready, 1'b1);
        check_eq("inj_ej_flit", ej_flit, mk(8'h33, 8'd2, inj_idx));
      end
      if (inj_valid && inj_ready) inj_idx++;
    end
    inj_valid = 1'b0;

    // Contention on ring_out: ring wins the first tie, loses the next.
    run_contention(1'b1);
    run_contention(1'b0);

    // Parallel: ring packet ejects while an injected packet goes downstream.
    ring_tag = 8'h55; ring_dest = 8'd2; ring_idx = 0; inj_idx = 0;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      drive_ring();
      inj_valid = (w >= 1 && inj_idx < NF);
      inj_flit  = mk(8'h56, 8'd7, inj_idx);
      ring_out_credit = ring_out_valid;
      #1;
      if (w >= 1 && w <= 9) begin
        check_eq("par_ej_valid", ej_valid, 1'b1);
        check_eq("par_ej_flit", ej_flit, mk(8'h55, 8'd2, w - 1));
        check_eq("par_inj_ready", inj_ready, 1'b1);
      end
      if (inj_valid && inj_ready) inj_idx++;
      if (w >= 2 && w <= 10) begin
        check_eq("par_out_valid", ring_out_valid, 1'b1);
        check_eq("par_out_flit", ring_out_flit, mk(8'h56, 8'd7, w - 2));
      end
      if (ring_in_credit) up_credit++;
    end
    inj_valid = 1'b0;

    // Credit exhaustion, single credit return, then credit overflow.
    do_reset();
    inj_idx = 0; outs = 0;
    for (int w = 0; w < 21; w++) begin
      @(negedge clk);
      inj_valid = (w <= 10);
      inj_flit  = mk(8'h66, 8'd5, inj_idx);
      ring_out_credit = (w == 8) || (w >= 12 && w <= 16);
      #1;
      if (w <= 7) check_eq("cr_inj_ready", inj_ready, (w < 4));
      if (w == 8) check_eq("cr_out_count", outs, 4);
      if (w == 8) check_eq("cr_same_cycle", inj_ready, 1'b0);
      if (w == 9) check_eq("cr_one_more", inj_ready, 1'b1);
      if (w == 10) begin
        check_eq("cr_stall_again", inj_ready, 1'b0);
        check_eq("cr_fifth_valid", ring_out_valid, 1'b1);
        check_eq("cr_fifth_flit", ring_out_flit, mk(8'h66, 8'd5, 4));
      end
      if (w == 11) check_eq("cr_idle", ring_out_valid, 1'b0);
      if (w >= 12 && w <= 16) check_eq("cr_no_overflow", overflow_err, 1'b0);
      if (w >= 17) check_eq("cr_overflow_sticky", overflow_err, 1'b1);
      if (inj_valid && inj_ready) inj_idx++;
      if (ring_out_valid) outs++;
    end
    inj_valid = 1'b0; ring_out_credit = 1'b0;

    // Reset in the middle of an ejecting packet.
    ring_tag = 8'h77; ring_dest = 8'd2; ring_idx = 0;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      drive_ring();
      #1;
      if (w >= 1) check_eq("rm_ej_flit", ej_flit, mk(8'h77, 8'd2, w - 1));
      if (ring_in_credit) up_credit++;
    end
    @(negedge clk);
    ring_in_valid = 1'b0;
    rst_l = 1'b0;
    #1;
    check_eq("rm_out_valid", ring_out_valid, 1'b0);
    check_eq("rm_out_flit", ring_out_flit, 64'h0);
    check_eq("rm_in_credit", ring_in_credit, 1'b0);
    check_eq("rm_overflow", overflow_err, 1'b0);
    check_eq("rm_ej_valid", ej_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    up_credit = 4;
    run_pass(8'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
